// File: rtl/dv_pkg.sv
// Shared DietVilk definitions: memory widths, read-owner encoding, tag layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dv_pkg;

  // Default memory geometry, shared with the DietVilk core.
  localparam int DV_ADDR_W = 16;
  localparam int DV_DATA_W = 16;

  // Which requester a read belongs to.
  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_LD   = 1'b1;

  // One in-flight read tag: valid bit plus owner.
  typedef struct packed {
    logic vld;
    logic own;
  } tag_t;

endpackage

// File: rtl/dv_tag_pipe.sv
// Shift register of {valid, owner} tags that follows reads through the memory.
// Latency: LAT cycles from in_* to out_*.
// Backpressure: none; advances every cycle, cleared by synchronous active-low reset.
module dv_tag_pipe
  import dv_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_vld,
  input  logic           in_own,
  output logic           out_vld,
  output logic           out_own,
  output logic [LAT-1:0] stage_vld
);

  tag_t stage [LAT];

  // Shift tags one stage per cycle; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= {in_vld, in_own};
      for (int i = 1; i < LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_vld = stage[LAT-1].vld;
  assign out_own = stage[LAT-1].own;

  // Flatten per-stage valid bits for the busy calculation upstream.
  always_comb begin
    stage_vld = '0;
    for (int i = 0; i < LAT; i++) begin
      stage_vld[i] = stage[i].vld;
    end
  end

endmodule

// File: rtl/dv_mem_arbiter.sv
// Two-requester arbiter for the shared DietVilk memory: core priority, loader starvation cap.
// Latency: gnt combinational; mem_* registered 1 cycle after gnt; read data 1+MEM_LAT after gnt.
// Backpressure: requester holds its request until gnt; at most one grant per cycle, no queuing.
module dv_mem_arbiter
  import dv_pkg::*;
#(
  parameter int ADDR_W     = DV_ADDR_W,
  parameter int DATA_W     = DV_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Stages below the last one keep busy high on the next cycle; the last stage drains out.
  localparam logic [MEM_LAT-1:0] KEEP_MASK = {MEM_LAT{1'b1}} >> 1;

  logic [3:0]         streak;
  logic [3:0]         streak_nxt;
  logic               at_cap;
  logic               grant_any;
  logic               mem_own;
  logic               tag_in_vld;
  logic               tag_out_vld;
  logic               tag_out_own;
  logic [MEM_LAT-1:0] tag_stage_vld;
  logic               busy_nxt;
  logic [DATA_W-1:0]  core_rdata_q;
  logic [DATA_W-1:0]  ld_rdata_q;

  assign at_cap    = (streak == 4'(MAX_STREAK));
  assign grant_any = core_gnt | ld_gnt;

  // Core wins unless the loader has waited through MAX_STREAK contested core grants.
  always_comb begin
    core_gnt   = 1'b0;
    ld_gnt     = 1'b0;
    streak_nxt = '0;
    if (reset) begin
      if (core_req && !(ld_req && at_cap)) begin
        core_gnt = 1'b1;
      end else if (ld_req) begin
        ld_gnt = 1'b1;
      end
      // Only a core grant that beat a waiting loader counts toward the cap.
      if (core_gnt && ld_req) begin
        streak_nxt = streak + 4'd1;
      end
    end
  end

  // Streak counter register.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      streak <= '0;
    end else begin
      streak <= streak_nxt;
    end
  end

  // Register the winner's access onto the memory port; hold fields when idle.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_own   <= OWN_CORE;
    end else begin
      mem_en <= grant_any;
      if (core_gnt) begin
        mem_we    <= core_we;
        mem_addr  <= core_addr;
        mem_wdata <= core_wdata;
        mem_own   <= OWN_CORE;
      end else if (ld_gnt) begin
        mem_we    <= ld_we;
        mem_addr  <= ld_addr;
        mem_wdata <= ld_wdata;
        mem_own   <= OWN_LD;
      end
    end
  end

  assign tag_in_vld = mem_en & ~mem_we;

  dv_tag_pipe #(
    .LAT (MEM_LAT)
  ) u_tag_pipe (
    .clk       (CLK),
    .reset     (reset),
    .in_vld    (tag_in_vld),
    .in_own    (mem_own),
    .out_vld   (tag_out_vld),
    .out_own   (tag_out_own),
    .stage_vld (tag_stage_vld)
  );

  assign core_rvalid = tag_out_vld & (tag_out_own == OWN_CORE);
  assign ld_rvalid   = tag_out_vld & (tag_out_own == OWN_LD);
  assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
  assign ld_rdata    = ld_rvalid   ? mem_rdata : ld_rdata_q;

  // Remember the last returned word per requester so rdata holds between returns.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      core_rdata_q <= '0;
      ld_rdata_q   <= '0;
    end else begin
      if (core_rvalid) core_rdata_q <= mem_rdata;
      if (ld_rvalid)   ld_rdata_q   <= mem_rdata;
    end
  end

  // busy next cycle: an access will be on mem_en, or a read tag will still be in the pipe.
  assign busy_nxt = grant_any | tag_in_vld | (|(tag_stage_vld & KEEP_MASK));

  // Registered busy, aligned with mem_en and the tag stages of the same cycle.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      busy <= 1'b0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule
